// File: rtl/reg_ring_master.sv
// Register-ring master: issues one request at the ring head, waits for the
// matching word at the ring tail (or a timeout) and reports completion to the core.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            core_req,
  input  logic                            core_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_wr_data,
  output logic                            core_rdy,
  output logic                            core_done,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_rd_data,
  output logic                            core_nack,
  output logic                            core_timeout,
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [7:0]                   CNT_LAST     = 8'(TIMEOUT - 1);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG      = UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [DW-1:0]                TIMEOUT_DATA = DW'(32'hdead_beef);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                       state_q, state_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         rdy_q, rdy_d;
  logic                         done_q, done_d;
  logic [DW-1:0]                rd_data_q, rd_data_d;
  logic                         nack_q, nack_d;
  logic                         tmo_q, tmo_d;
  logic                         req_out_q, req_out_d;
  logic                         rdwr_out_q, rdwr_out_d;
  logic [AW-1:0]                addr_out_q, addr_out_d;
  logic [DW-1:0]                data_out_q, data_out_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_out_q, src_out_d;
  logic                         ret_hit;

  // The master is the ring terminus: tail address and direction carry no information for it.
  logic unused_tail;
  assign unused_tail = ^{reg_rd_wr_L_in, reg_addr_in};

  assign ret_hit = reg_req_in && (reg_src_in == SRC_TAG);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_data_d  = rd_data_q;
    nack_d     = nack_q;
    tmo_d      = tmo_q;
    req_out_d  = 1'b0;
    rdwr_out_d = rdwr_out_q;
    addr_out_d = addr_out_q;
    data_out_d = '0;
    src_out_d  = src_out_q;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          state_d    = S_ISSUE;
          req_out_d  = 1'b1;
          rdwr_out_d = core_rd_wr_L;
          addr_out_d = core_addr;
          data_out_d = core_wr_data;
          src_out_d  = SRC_TAG;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A return on the final counted cycle still beats the timeout.
        if (ret_hit) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          rd_data_d = reg_data_in;
          nack_d    = !reg_ack_in;
          tmo_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          rd_data_d = TIMEOUT_DATA;
          nack_d    = 1'b0;
          tmo_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      nack_q     <= 1'b0;
      tmo_q      <= 1'b0;
      req_out_q  <= 1'b0;
      rdwr_out_q <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      src_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      nack_q     <= nack_d;
      tmo_q      <= tmo_d;
      req_out_q  <= req_out_d;
      rdwr_out_q <= rdwr_out_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      src_out_q  <= src_out_d;
    end
  end

  assign core_rdy        = rdy_q;
  assign core_done       = done_q;
  assign core_rd_data    = rd_data_q;
  assign core_nack       = nack_q;
  assign core_timeout    = tmo_q;
  assign reg_req_out     = req_out_q;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = rdwr_out_q;
  assign reg_addr_out    = addr_out_q;
  assign reg_data_out    = data_out_q;
  assign reg_src_out     = src_out_q;

endmodule

// File: tb/tb_reg_ring_master.sv
// Bench for reg_ring_master: directed and randomized transactions checked
// against a cycle-level model of when and how each transaction completes.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_reg_ring_master;
  localparam int AW         = `UDP_REG_ADDR_WIDTH;
  localparam int DW         = `CPCI_NF2_DATA_WIDTH;
  localparam int SW         = 2;
  localparam int SRC_ID     = 0;
  localparam int TIMEOUT    = 64;
  localparam int TXN_CYCLES = TIMEOUT + 10;
  localparam logic [SW-1:0] MY_SRC    = SW'(SRC_ID);
  localparam logic [SW-1:0] OTHER_SRC = SW'(SRC_ID + 1);
  localparam logic [DW-1:0] TMO_DATA  = 32'hdead_beef;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_req, core_rd_wr_L;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wr_data;
  logic          core_rdy, core_done, core_nack, core_timeout;
  logic [DW-1:0] core_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by do_txn, judged by the calling test.
  int            o_req_cnt, o_done_cnt, o_done_t, o_issue_t, o_rdy_low_after;
  logic          o_ack_seen, o_issue_rdwr, o_nack, o_tmo, o_rdwr_after;
  logic [AW-1:0] o_issue_addr, o_addr_after;
  logic [DW-1:0] o_issue_data, o_data_after, o_rd_data, o_hold_data;
  logic [SW-1:0] o_issue_src;

  reg_ring_master #(.UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC_ID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_rd_wr_L(core_rd_wr_L), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_rdy(core_rdy), .core_done(core_done),
    .core_rd_data(core_rd_data), .core_nack(core_nack), .core_timeout(core_timeout),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_rd_wr_L = 1'b0; core_addr = '0; core_wr_data = '0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  // Model: a return is honoured if it arrives during one of the TIMEOUT wait cycles.
  function automatic bit model_returned(input int ret_k);
    return (ret_k >= 0) && (ret_k < TIMEOUT);
  endfunction

  // Issue is cycle 1, waiting starts cycle 2; completion shows one cycle after the deciding wait cycle.
  function automatic int model_done_t(input int ret_k);
    if (model_returned(ret_k)) return 2 + ret_k + 1;
    return 2 + (TIMEOUT - 1) + 1;
  endfunction

  // Runs one transaction. ret_k/bad_k: wait-cycle index at which a matching/foreign
  // word appears at the tail (-1 = never). Cycle t=1 is the cycle after acceptance.
  task automatic do_txn(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ret_k, input logic ack, input logic [DW-1:0] rdata,
                        input int bad_k, input bit pulse_wait);
    o_req_cnt = 0; o_done_cnt = 0; o_done_t = -1; o_issue_t = -1; o_rdy_low_after = 0;
    o_ack_seen = 1'b0; o_rd_data = '0; o_nack = 1'b0; o_tmo = 1'b0;
    core_req = 1'b1; core_rd_wr_L = rd; core_addr = addr; core_wr_data = wdata;
    tick();
    core_req = 1'b0;
    for (int t = 1; t <= TXN_CYCLES; t++) begin
      if (reg_req_out === 1'b1) begin
        o_req_cnt++;
        if (o_issue_t < 0) begin
          o_issue_t = t; o_issue_rdwr = reg_rd_wr_L_out; o_issue_addr = reg_addr_out;
          o_issue_data = reg_data_out; o_issue_src = reg_src_out;
        end
      end
      if (reg_ack_out !== 1'b0) o_ack_seen = 1'b1;
      if (t == 2) begin
        o_data_after = reg_data_out; o_addr_after = reg_addr_out; o_rdwr_after = reg_rd_wr_L_out;
      end
      if (core_done === 1'b1) begin
        o_done_cnt++; o_done_t = t;
        o_rd_data = core_rd_data; o_nack = core_nack; o_tmo = core_timeout;
      end else if (o_done_t >= 0 && t > o_done_t && core_rdy !== 1'b1) begin
        o_rdy_low_after++;
      end
      o_hold_data = core_rd_data;
      reg_addr_in = AW'($urandom); reg_rd_wr_L_in = rd;
      if (t - 2 == ret_k) begin
        reg_req_in = 1'b1; reg_ack_in = ack; reg_src_in = MY_SRC; reg_data_in = rdata;
      end else if (t - 2 == bad_k) begin
        reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = OTHER_SRC; reg_data_in = $urandom;
      end else begin
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_src_in = '0; reg_data_in = '0;
      end
      core_req = pulse_wait && (t == 3);
      core_addr = pulse_wait ? ~addr : addr;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    n_checks++; if (core_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_core_rdy: got %b want 1", core_rdy); end
    n_checks++; if ({core_done, core_nack, core_timeout, reg_req_out, reg_ack_out, reg_rd_wr_L_out} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
        {core_done, core_nack, core_timeout, reg_req_out, reg_ack_out, reg_rd_wr_L_out}); end
    n_checks++; if (core_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", core_rd_data); end
    n_checks++; if ({reg_addr_out, reg_data_out, reg_src_out} !== '0) begin n_fail++;
      $display("FAIL reset_ring_head: got %h/%h/%h want 0", reg_addr_out, reg_data_out, reg_src_out); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    tick();
    n_checks++; if (core_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_exit_rdy: got %b want 1", core_rdy); end
  endtask

  task automatic test_read();
    do_txn(1'b1, 23'h400001, $urandom, 2, 1'b1, 32'h1234_5678, -1, 1'b0);
    n_checks++; if (o_issue_t !== 1) begin n_fail++; $display("FAIL read_issue_cycle: got %0d want 1", o_issue_t); end
    n_checks++; if (o_req_cnt !== 1) begin n_fail++; $display("FAIL read_req_pulses: got %0d want 1", o_req_cnt); end
    n_checks++; if ({o_issue_rdwr, o_issue_addr, o_issue_src} !== {1'b1, 23'h400001, MY_SRC}) begin n_fail++;
      $display("FAIL read_issue_fields: got %b/%h/%h want 1/400001/%h", o_issue_rdwr, o_issue_addr, o_issue_src, MY_SRC); end
    n_checks++; if (o_done_cnt !== 1) begin n_fail++; $display("FAIL read_done_pulses: got %0d want 1", o_done_cnt); end
    n_checks++; if (o_done_t !== model_done_t(2)) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", o_done_t, model_done_t(2)); end
    n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {32'h1234_5678, 2'b00}) begin n_fail++;
      $display("FAIL read_status: got %h/%b/%b want 12345678/0/0", o_rd_data, o_nack, o_tmo); end
  endtask

  task automatic test_write();
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    int k;
    a = AW'($urandom); rd = $urandom; k = int'($urandom_range(0, 10));
    do_txn(1'b0, a, 32'hA5A5_A5A5, k, 1'b1, rd, -1, 1'b0);
    n_checks++; if (o_req_cnt !== 1) begin n_fail++; $display("FAIL write_req_pulses: got %0d want 1", o_req_cnt); end
    n_checks++; if ({o_issue_rdwr, o_issue_data} !== {1'b0, 32'hA5A5_A5A5}) begin n_fail++;
      $display("FAIL write_issue_fields: got %b/%h want 0/a5a5a5a5", o_issue_rdwr, o_issue_data); end
    n_checks++; if (o_ack_seen !== 1'b0) begin n_fail++; $display("FAIL write_ack_out: got %b want 0", o_ack_seen); end
    n_checks++; if ({o_data_after, o_addr_after, o_rdwr_after} !== {32'h0, a, 1'b0}) begin n_fail++;
      $display("FAIL write_head_after_issue: got %h/%h/%b want 0/%h/0", o_data_after, o_addr_after, o_rdwr_after, a); end
    n_checks++; if ({o_done_cnt, o_done_t} !== {32'd1, 32'(model_done_t(k))}) begin n_fail++;
      $display("FAIL write_done: got %0d pulses at %0d want 1 at %0d", o_done_cnt, o_done_t, model_done_t(k)); end
    n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {rd, 2'b00}) begin n_fail++;
      $display("FAIL write_status: got %h/%b/%b want %h/0/0", o_rd_data, o_nack, o_tmo, rd); end
  endtask

  task automatic test_nack();
    logic [DW-1:0] rd;
    rd = $urandom;
    do_txn(1'b1, AW'($urandom), '0, 5, 1'b0, rd, -1, 1'b0);
    n_checks++; if (o_done_cnt !== 1) begin n_fail++; $display("FAIL nack_done_pulses: got %0d want 1", o_done_cnt); end
    n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {rd, 2'b10}) begin n_fail++;
      $display("FAIL nack_status: got %h/%b/%b want %h/1/0", o_rd_data, o_nack, o_tmo, rd); end
  endtask

  task automatic test_timeout();
    do_txn(1'b1, AW'($urandom), '0, 68, 1'b1, 32'h0bad_0bad, -1, 1'b0);
    n_checks++; if (o_done_cnt !== 1) begin n_fail++; $display("FAIL timeout_done_pulses: got %0d want 1", o_done_cnt); end
    n_checks++; if (o_done_t !== TIMEOUT + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", o_done_t, TIMEOUT + 2); end
    n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {TMO_DATA, 2'b01}) begin n_fail++;
      $display("FAIL timeout_status: got %h/%b/%b want deadbeef/0/1", o_rd_data, o_nack, o_tmo); end
    n_checks++; if (o_rdy_low_after !== 0) begin n_fail++; $display("FAIL timeout_late_return_rdy: got %0d busy cycles want 0", o_rdy_low_after); end
    n_checks++; if (o_hold_data !== TMO_DATA) begin n_fail++; $display("FAIL timeout_hold: got %h want deadbeef", o_hold_data); end
    do_txn(1'b1, AW'($urandom), '0, TIMEOUT, 1'b1, 32'h1111_2222, -1, 1'b0);
    n_checks++; if ({o_done_t, o_tmo} !== {32'(TIMEOUT + 2), 1'b1}) begin n_fail++;
      $display("FAIL timeout_one_late: got t=%0d tmo=%b want t=%0d tmo=1", o_done_t, o_tmo, TIMEOUT + 2); end
  endtask

  task automatic test_filter_collision();
    logic [DW-1:0] rd;
    rd = $urandom;
    do_txn(1'b1, AW'($urandom), '0, TIMEOUT - 1, 1'b1, rd, 3, 1'b1);
    n_checks++; if (o_req_cnt !== 1) begin n_fail++; $display("FAIL collide_no_reissue: got %0d issues want 1", o_req_cnt); end
    n_checks++; if ({o_done_cnt, o_done_t} !== {32'd1, 32'(TIMEOUT + 2)}) begin n_fail++;
      $display("FAIL collide_done: got %0d pulses at %0d want 1 at %0d", o_done_cnt, o_done_t, TIMEOUT + 2); end
    n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {rd, 2'b00}) begin n_fail++;
      $display("FAIL collide_status: got %h/%b/%b want %h/0/0", o_rd_data, o_nack, o_tmo, rd); end
    do_txn(1'b0, AW'($urandom), $urandom, -1, 1'b1, '0, 1, 1'b0);
    n_checks++; if ({o_rd_data, o_tmo} !== {TMO_DATA, 1'b1}) begin n_fail++;
      $display("FAIL foreign_src_ignored: got %h/%b want deadbeef/1", o_rd_data, o_tmo); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic          rd, ack;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rdat, exp_data;
      int            k, b;
      logic          exp_nack, exp_tmo;
      rd = 1'($urandom); ack = 1'($urandom); a = AW'($urandom); wd = $urandom; rdat = $urandom;
      k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 6));
      b = int'($urandom_range(0, TIMEOUT + 6));
      if (b == k) b = -1;
      do_txn(rd, a, wd, k, ack, rdat, b, 1'($urandom));
      exp_data = model_returned(k) ? rdat : TMO_DATA;
      exp_nack = model_returned(k) ? !ack : 1'b0;
      exp_tmo  = !model_returned(k);
      n_checks++; if ({o_req_cnt, o_done_cnt, o_done_t} !== {32'd1, 32'd1, 32'(model_done_t(k))}) begin n_fail++;
        $display("FAIL rand%0d_timing: got req=%0d done=%0d t=%0d want 1/1/%0d", i, o_req_cnt, o_done_cnt, o_done_t, model_done_t(k)); end
      n_checks++; if ({o_issue_rdwr, o_issue_addr, o_issue_data} !== {rd, a, wd}) begin n_fail++;
        $display("FAIL rand%0d_issue: got %b/%h/%h want %b/%h/%h", i, o_issue_rdwr, o_issue_addr, o_issue_data, rd, a, wd); end
      n_checks++; if ({o_rd_data, o_nack, o_tmo} !== {exp_data, exp_nack, exp_tmo}) begin n_fail++;
        $display("FAIL rand%0d_status: got %h/%b/%b want %h/%b/%b", i, o_rd_data, o_nack, o_tmo, exp_data, exp_nack, exp_tmo); end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    core_req = 1'b1; core_rd_wr_L = 1'b1; core_addr = 23'h2a_5a5a;
    tick();
    core_req = 1'b0;
    tick(); tick(); tick();
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({core_rdy, core_done, core_nack, core_timeout, reg_req_out, reg_rd_wr_L_out} !== 6'b100000) begin n_fail++;
      $display("FAIL midreset_flags: got %b want 100000",
        {core_rdy, core_done, core_nack, core_timeout, reg_req_out, reg_rd_wr_L_out}); end
    n_checks++; if ({reg_addr_out, reg_src_out, core_rd_data} !== '0) begin n_fail++;
      $display("FAIL midreset_values: got %h/%h/%h want 0", reg_addr_out, reg_src_out, core_rd_data); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = MY_SRC; reg_data_in = 32'h5555_aaaa;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_done !== 1'b0) dones++;
    end
    idle_inputs();
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones); end
    n_checks++; if ({core_rdy, core_rd_data} !== {1'b1, 32'h0}) begin n_fail++;
      $display("FAIL midreset_return_dropped: got rdy=%b data=%h want 1/0", core_rdy, core_rd_data); end
  endtask

  task automatic test_reset_exit();
    #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1; core_req = 1'b1; core_rd_wr_L = 1'b1; core_addr = 23'h13_579b;
    tick();
    core_req = 1'b0;
    n_checks++; if ({reg_req_out, reg_addr_out} !== {1'b1, 23'h13_579b}) begin n_fail++;
      $display("FAIL reset_exit_accept: got %b/%h want 1/13579b", reg_req_out, reg_addr_out); end
    for (int i = 0; i < TIMEOUT + 4; i++) tick();
    n_checks++; if ({core_rdy, core_timeout} !== 2'b11) begin n_fail++;
      $display("FAIL reset_exit_complete: got rdy=%b tmo=%b want 1/1", core_rdy, core_timeout); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nack();
    test_timeout();
    test_filter_collision();
    test_random();
    test_reset_mid();
    test_reset_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
